// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter
//  Function : Shares the register file write port between the pipeline WB
//             stream and buffered long-latency results; keeps a busy-register
//             scoreboard. Optional starvation stall: RF_ARB_STARVE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_wr,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_addr,
    input  logic [31:0] ll_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic [31:0] busy_mask,
    output logic        stall_req,
    output logic        issue_err,
    output logic        rf_wr,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [4:0]         r_fifo_addr [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_alive;
    logic [31:0]        r_busy;
    logic               r_issue_err;

    logic               w_push;
    logic               w_pop;
    logic               w_fifo_nonempty;
    logic               w_wb_req;
    logic               w_wb_grant;
    logic               w_stall;
    logic [4:0]         w_head_addr;
    logic [31:0]        w_head_data;
    logic [31:0]        w_set_vec;
    logic [31:0]        w_clr_vec;

    // r_alive holds ll_ready and the write port low until the first edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    assign w_fifo_nonempty = (r_count != '0);
    assign ll_ready        = r_alive && (r_count < c_DEPTH);
    assign w_push          = ll_valid && ll_ready;
    assign w_wb_req        = wb_wr && (wb_addr != 5'd0);
    assign w_wb_grant      = r_alive && !w_stall && w_wb_req;
    assign w_pop           = w_fifo_nonempty && (w_stall || !w_wb_req);
    assign w_head_addr     = r_fifo_addr[r_rd_ptr];
    assign w_head_data     = r_fifo_data[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= ll_addr;
            r_fifo_data[r_wr_ptr] <= ll_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        rf_wr   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (w_wb_grant) begin
            rf_wr   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (w_pop) begin
            // a popped r0 entry consumes the slot but never writes
            rf_wr   = (w_head_addr != 5'd0);
            rf_addr = w_head_addr;
            rf_data = w_head_data;
        end
    end

    assign w_set_vec = (issue_valid && (issue_addr != 5'd0)) ? (32'd1 << issue_addr) : 32'd0;
    assign w_clr_vec = (w_pop && (w_head_addr != 5'd0)) ? (32'd1 << w_head_addr) : 32'd0;

    // Set is applied after clear so a same-cycle issue to the written register stays busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= 32'd0;
            r_issue_err <= 1'b0;
        end else begin
            r_busy      <= ((r_busy & ~w_clr_vec) | w_set_vec) & ~32'd1;
            r_issue_err <= r_issue_err | ((w_set_vec & r_busy) != 32'd0);
        end
    end

    assign busy_mask = r_busy;
    assign issue_err = r_issue_err;

`ifdef RF_ARB_STARVE_EN
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;
    logic       r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= 4'd0;
            r_stall  <= 1'b0;
        end else begin
            if (!w_fifo_nonempty || w_pop) begin
                r_starve <= 4'd0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
            r_stall <= w_fifo_nonempty && !w_pop && (r_starve == c_STARVE_MAX);
        end
    end

    assign w_stall = r_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign stall_req = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Function : Directed self-checking bench for rf_write_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [31:0] busy_mask;
    logic        stall_req;
    logic        issue_err;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .wb_wr       (wb_wr),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ll_valid    (ll_valid),
        .ll_ready    (ll_ready),
        .ll_addr     (ll_addr),
        .ll_data     (ll_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy_mask   (busy_mask),
        .stall_req   (stall_req),
        .issue_err   (issue_err),
        .rf_wr       (rf_wr),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        ll_valid = 1'b1;
        ll_addr  = a;
        ll_data  = d;
        tick();
        ll_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wb_wr = 1'b0; wb_addr = '0; wb_data = '0;
        ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
        repeat (2) tick();
        check("rst_ll_ready", 32'(ll_ready), 32'd0);
        check("rst_rf_wr", 32'(rf_wr), 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_err", 32'(issue_err), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_pre_edge", 32'(ll_ready), 32'd0);
        tick();
        check("ready_post_edge", 32'(ll_ready), 32'd1);

        // LL push to r5 is written the following cycle
        push(5'd5, 32'h1234);
        #1;
        check("ll_wr", 32'(rf_wr), 32'd1);
        check("ll_addr", 32'(rf_addr), 32'd5);
        check("ll_data", rf_data, 32'h1234);
        check("ll_ready_1", 32'(ll_ready), 32'd1);
        tick();
        check("idle_wr", 32'(rf_wr), 32'd0);

        // WB has priority over a waiting FIFO head
        wb_wr = 1'b1; wb_addr = 5'd3; wb_data = 32'hAAAA;
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'h5555;
        #1;
        check("wb_prio_addr", 32'(rf_addr), 32'd3);
        check("wb_prio_data", rf_data, 32'hAAAA);
        tick();
        ll_valid = 1'b0;
        wb_addr = 5'd4; wb_data = 32'hBBBB;
        #1;
        check("wb_prio2_addr", 32'(rf_addr), 32'd4);
        tick();
        wb_wr = 1'b0;
        #1;
        check("head_after_wb_addr", 32'(rf_addr), 32'd9);
        check("head_after_wb_data", rf_data, 32'h5555);
        tick();

        // wb_wr to r0 does not occupy the port
        push(5'd10, 32'h77);
        wb_wr = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        #1;
        check("wb_r0_wr", 32'(rf_wr), 32'd1);
        check("wb_r0_addr", 32'(rf_addr), 32'd10);
        check("wb_r0_data", rf_data, 32'h77);
        tick();
        wb_wr = 1'b0;

        // r0 LL entry is popped silently
        push(5'd0, 32'hDEAD);
        #1;
        check("ll_r0_wr", 32'(rf_wr), 32'd0);
        tick();
        check("ll_r0_gone", 32'(rf_wr), 32'd0);

        // Two pushes under continuous WB traffic fill the FIFO
        wb_wr = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
        push(5'd11, 32'hB1);
        ll_valid = 1'b1; ll_addr = 5'd12; ll_data = 32'hB2;
        #1;
        check("ready_one_entry", 32'(ll_ready), 32'd1);
        tick();
        ll_valid = 1'b0;
        #1;
        check("full_ready", 32'(ll_ready), 32'd0);
`ifdef RF_ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            check("starve_no_stall", 32'(stall_req), 32'd0);
            check("starve_wb_addr", 32'(rf_addr), 32'd1);
            tick();
        end
        check("stall_high", 32'(stall_req), 32'd1);
        check("stall_head_wr", 32'(rf_wr), 32'd1);
        check("stall_head_addr", 32'(rf_addr), 32'd11);
        check("stall_head_data", rf_data, 32'hB1);
        tick();
        check("stall_low", 32'(stall_req), 32'd0);
        check("post_stall_wb", 32'(rf_addr), 32'd1);
        tick();
        wb_wr = 1'b0;
        #1;
        check("drain_addr2", 32'(rf_addr), 32'd12);
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            check("no_stall", 32'(stall_req), 32'd0);
            check("strict_wb_addr", 32'(rf_addr), 32'd1);
            tick();
        end
        wb_wr = 1'b0;
        #1;
        check("drain_addr1", 32'(rf_addr), 32'd11);
        check("drain_data1", rf_data, 32'hB1);
        tick();
        check("drain_addr2", 32'(rf_addr), 32'd12);
        tick();
`endif
        check("drained_wr", 32'(rf_wr), 32'd0);
        check("drained_ready", 32'(ll_ready), 32'd1);

        // Scoreboard set/clear, sticky error, set-wins
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("busy_set", busy_mask, 32'h80);
        check("err_clean", 32'(issue_err), 32'd0);
        push(5'd7, 32'h70);
        #1;
        check("busy_hold_wr_cycle", busy_mask, 32'h80);
        check("r7_write", 32'(rf_addr), 32'd7);
        tick();
        check("busy_clear", busy_mask, 32'h0);
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        #1;
        check("err_not_yet", 32'(issue_err), 32'd0);
        tick();
        issue_valid = 1'b0;
        check("err_set", 32'(issue_err), 32'd1);
        tick();
        check("err_sticky", 32'(issue_err), 32'd1);
        push(5'd7, 32'h71);
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("set_wins", busy_mask, 32'h80);
        push(5'd7, 32'h72);
        tick();
        check("busy_clear2", busy_mask, 32'h0);

        // Reset with buffered entries and busy registers
        wb_wr = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
        issue_valid = 1'b1; issue_addr = 5'd2;
        ll_valid = 1'b1; ll_addr = 5'd20; ll_data = 32'h1;
        tick();
        issue_addr = 5'd5; ll_addr = 5'd21; ll_data = 32'h2;
        tick();
        issue_valid = 1'b0; ll_valid = 1'b0;
        check("pre_rst_busy", busy_mask, 32'h24);
        check("pre_rst_ready", 32'(ll_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("arst_busy", busy_mask, 32'h0);
        check("arst_err", 32'(issue_err), 32'd0);
        check("arst_ready", 32'(ll_ready), 32'd0);
        check("arst_rf_wr", 32'(rf_wr), 32'd0);
        check("arst_stall", 32'(stall_req), 32'd0);
        wb_wr = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(ll_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_wr", 32'(rf_wr), 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbiter and scheduler for the register file's single write port. Shares that port between the in-order pipeline writeback stream and a long-latency unit (multiplier/divider) result stream. Long-latency results are buffered in a small FIFO, and a starvation counter can request a pipeline stall. A 32-bit scoreboard tracks destinations of outstanding long-latency ops for the hazard unit. Sits between the WB stage / long-latency unit and the register file's wr/addr3/data3 inputs.

## Interface

- DEPTH, 2, long-latency result FIFO entries; power of 2, ≥2
- STARVE_LIMIT, 4, cycles a non-empty FIFO may go unserved before stall_req; 1..15
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- wb_wr  in  1  pipeline writeback request
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  FIFO can accept; transfer when ll_valid && ll_ready
- ll_addr  in  5  long-latency destination register
- ll_data  in  32  long-latency result
- issue_valid  in  1  long-latency op issued this cycle
- issue_addr  in  5  its destination register
- busy_mask  out  32  bit n = register n has an outstanding long-latency write; bit 0 always 0
- stall_req  out  1  pipeline must freeze WB stage
- issue_err  out  1  sticky: issue to an already-busy register
- rf_wr  out  1  register file write enable
- rf_addr  out  5  register file write address
- rf_data  out  32  register file write data

## Operation

- Write to register 0 counts as no request. wb_wr with wb_addr==0 does not occupy the port. A pushed entry with ll_addr==0 is popped without asserting rf_wr.
- Port grant, evaluated each cycle:
  - stall_req==0: WB if wb_wr && wb_addr!=0; else FIFO head if non-empty; else idle.
  - stall_req==1: FIFO head always granted. Any wb_wr is not written; the pipeline holds and re-presents it.
- rf_wr/rf_addr/rf_data are a combinational mux of the granted source. rf_wr=0 when idle.
- FIFO: push on ll_valid && ll_ready. Pop on grant. ll_ready = count<DEPTH. A pop does not raise ll_ready in the same cycle, so a full FIFO never pushes and pops in one cycle. Pointers wrap modulo DEPTH.
- Scoreboard:
  - issue_valid && issue_addr!=0 sets busy[issue_addr].
  - An LL write to register n clears busy[n].
  - Set and clear of the same register in the same cycle: set wins.
  - Issue to a register whose bit is already 1 sets issue_err, held until reset.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and not popped, saturating at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
  - stall_req is registered: high the cycle after the counter reaches STARVE_LIMIT, low the cycle after the pop.

## Timing

- Reset (async assert): FIFO empty, count=0, busy_mask=0, starve counter=0, stall_req=0, issue_err=0, ll_ready=0, rf_wr=0. ll_ready=1 from the first clock edge after deassert.
- WB write latency 0: rf_wr in the same cycle as wb_wr.
- LL write latency: at least 1 cycle. An entry pushed at edge k can be written in cycle k+1 at the earliest.
- busy_mask updates on the edge ending the issue/write cycle.
- Worst-case LL wait with the feature on: STARVE_LIMIT+2 cycles at the FIFO head.
- Reset mid-operation discards buffered entries and scoreboard state. The pipeline flushes correspondingly.

## Configuration

- RF_ARB_STARVE_EN
  - Defined: starvation counter and stall_req as above.
  - Undefined: no counter. stall_req tied 0. Strict WB priority; the FIFO drains only in WB-idle cycles.

## Test plan

- Reset, then ll push of (r5, 0x1234) with no WB traffic → rf_wr=1, rf_addr=5, rf_data=0x1234 the next cycle; ll_ready=1 throughout.
- Same-cycle wb_wr(r3, 0xAAAA) and non-empty FIFO → WB written; FIFO head written the first cycle wb_wr=0 or wb_addr=0.
- Two pushes with continuous WB writes → ll_ready=0 with count=2. With RF_ARB_STARVE_EN: stall_req rises after 4 unserved cycles, the head is written, wb_wr is ignored in that cycle, and stall_req falls the following cycle.
- issue r7, then an LL write to r7 → busy_mask=0x80 until the write edge, then 0. Issue r7 twice without a write → issue_err=1 sticky.
- Push with ll_addr=0 → popped, rf_wr stays 0. wb_wr with wb_addr=0 → FIFO granted that cycle.
- Assert reset with 2 entries buffered and busy_mask=0x24 → all outputs reach reset values immediately; no rf_wr after deassert.
